// File: rtl/max_pooling.sv
// max_pooling: registered 2x2 max-pool with winning index, 1-cycle latency, optional signed compare
module max_pooling #(
  parameter int DATA_W = 4,
  parameter bit SIGNED_MODE = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              enable,
  input  logic [DATA_W-1:0] input1,
  input  logic [DATA_W-1:0] input2,
  input  logic [DATA_W-1:0] input3,
  input  logic [DATA_W-1:0] input4,
  output logic [DATA_W-1:0] output1,
  output logic [1:0]        max_idx,
  output logic              done
);
  // Flipping the MSB maps two's-complement order onto unsigned order
  localparam logic [DATA_W-1:0] FLIP = DATA_W'(SIGNED_MODE) << (DATA_W - 1);
  logic [DATA_W-1:0] m01, m23, res;
  logic [1:0] i01, i23, ires;
  logic g01, g23, gres;
  always_comb begin
    g01  = (input2 ^ FLIP) > (input1 ^ FLIP);
    g23  = (input4 ^ FLIP) > (input3 ^ FLIP);
    m01  = g01 ? input2 : input1;
    i01  = g01 ? 2'd1 : 2'd0;
    m23  = g23 ? input4 : input3;
    i23  = g23 ? 2'd3 : 2'd2;
    gres = (m23 ^ FLIP) > (m01 ^ FLIP);
    res  = gres ? m23 : m01;
    ires = gres ? i23 : i01;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      output1 <= '0;
      max_idx <= '0;
      done    <= 1'b0;
    end else begin
      done <= enable;
      if (enable) begin
        output1 <= res;
        max_idx <= ires;
      end
    end
  end
endmodule

// File: tb/tb_max_pooling.sv
// tb_max_pooling: table-driven and sequence checks for unsigned and signed max_pooling instances
module tb_max_pooling;
  logic clk = 0, rst = 1, enable = 0;
  logic [3:0] in1 = 0, in2 = 0, in3 = 0, in4 = 0;
  logic [3:0] u_out, s_out;
  logic [1:0] u_idx, s_idx;
  logic u_done, s_done;
  int passed = 0, total = 0;

  always #5 clk = ~clk;

  max_pooling #(.DATA_W(4), .SIGNED_MODE(0)) dut_u (
    .clk(clk), .rst(rst), .enable(enable),
    .input1(in1), .input2(in2), .input3(in3), .input4(in4),
    .output1(u_out), .max_idx(u_idx), .done(u_done));

  max_pooling #(.DATA_W(4), .SIGNED_MODE(1)) dut_s (
    .clk(clk), .rst(rst), .enable(enable),
    .input1(in1), .input2(in2), .input3(in3), .input4(in4),
    .output1(s_out), .max_idx(s_idx), .done(s_done));

  typedef struct {
    logic       r, e;
    logic [3:0] a, b, c, d;
    logic [3:0] out;
    logic [1:0] idx;
    logic       dn;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic step(input logic r, input logic e, input logic [3:0] a, b, c, d);
    rst = r; enable = e; in1 = a; in2 = b; in3 = c; in4 = d;
    @(posedge clk);
    #1;
  endtask

  task automatic check_u(input string tag, input logic [3:0] o, input logic [1:0] i, input logic dn);
    check({tag, ".out"}, u_out, o);
    check({tag, ".idx"}, u_idx, i);
    check({tag, ".done"}, u_done, dn);
  endtask

  vec_t tbl [11];
  logic [3:0] sw [9][4];
  logic [3:0] smax [9];
  logic [1:0] sidx [9];

  initial begin
    tbl[0]  = '{1, 1, 15, 15, 15, 15, 0, 0, 0};
    tbl[1]  = '{1, 1, 15, 15, 15, 15, 0, 0, 0};
    tbl[2]  = '{0, 1, 3, 9, 2, 7, 9, 1, 1};
    tbl[3]  = '{0, 0, 1, 1, 1, 1, 9, 1, 0};
    tbl[4]  = '{0, 1, 6, 6, 6, 6, 6, 0, 1};
    tbl[5]  = '{0, 1, 2, 4, 4, 1, 4, 1, 1};
    tbl[6]  = '{0, 1, 1, 2, 3, 15, 15, 3, 1};
    tbl[7]  = '{0, 1, 0, 0, 0, 0, 0, 0, 1};
    tbl[8]  = '{0, 1, 5, 5, 7, 7, 7, 2, 1};
    tbl[9]  = '{0, 0, 15, 15, 15, 15, 7, 2, 0};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 7, 2, 0};

    sw[0] = '{5, 1, 2, 3};   smax[0] = 5;  sidx[0] = 0;
    sw[1] = '{0, 8, 8, 1};   smax[1] = 8;  sidx[1] = 1;
    sw[2] = '{15, 15, 0, 0}; smax[2] = 15; sidx[2] = 0;
    sw[3] = '{1, 0, 1, 0};   smax[3] = 1;  sidx[3] = 0;
    sw[4] = '{0, 0, 0, 0};   smax[4] = 0;  sidx[4] = 0;
    sw[5] = '{3, 4, 12, 11}; smax[5] = 12; sidx[5] = 2;
    sw[6] = '{7, 2, 6, 7};   smax[6] = 7;  sidx[6] = 0;
    sw[7] = '{1, 1, 1, 3};   smax[7] = 3;  sidx[7] = 3;
    sw[8] = '{9, 10, 2, 10}; smax[8] = 10; sidx[8] = 1;

    #2;
    for (int i = 0; i < 11; i++) begin
      step(tbl[i].r, tbl[i].e, tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d);
      check_u($sformatf("vec%0d", i), tbl[i].out, tbl[i].idx, tbl[i].dn);
    end
    check("rst.s_done", s_done, 0);

    for (int i = 0; i < 9; i++) begin
      step(0, 1, sw[i][0], sw[i][1], sw[i][2], sw[i][3]);
      check_u($sformatf("stream%0d", i), smax[i], sidx[i], 1);
    end
    step(0, 0, 0, 0, 0, 0);
    check_u("stream_end", 10, 1, 0);

    step(0, 1, 4'b1111, 4'b0001, 4'b1000, 4'b0000);
    check_u("mode_u", 4'b1111, 0, 1);
    check("mode_s.out", s_out, 4'b0001);
    check("mode_s.idx", s_idx, 1);
    check("mode_s.done", s_done, 1);
    step(0, 1, 8, 8, 9, 15);
    check("neg_s.out", s_out, 15);
    check("neg_s.idx", s_idx, 3);
    step(0, 1, 7, 8, 0, 15);
    check("mix_s.out", s_out, 7);
    check("mix_s.idx", s_idx, 0);
    check_u("mix_u", 15, 3, 1);

    step(0, 1, 3, 9, 2, 7);
    check_u("mid_pre", 9, 1, 1);
    step(1, 1, 15, 15, 15, 15);
    check_u("mid_rst", 0, 0, 0);
    check("mid_rst.s_out", s_out, 0);
    step(0, 1, 4, 2, 1, 0);
    check_u("mid_resume", 4, 0, 1);
    step(0, 0, 0, 0, 0, 0);
    check_u("mid_hold", 4, 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/max_pooling.md
MAX_POOLING -- requirements
Module: max_pooling

Interface
- REQ-001 Parameter DATA_W, default 4: bit width of each input sample and of output1.
- REQ-002 Parameter SIGNED_MODE, default 0: 0 = compare inputs as unsigned, 1 = compare as two's-complement signed.
- REQ-003 clk  input  1: clock; all state updates on the rising edge.
- REQ-004 rst  input  1: reset; synchronous, active-high.
- REQ-005 enable  input  1: input window valid; when high, input1..input4 form one 2x2 pooling window.
- REQ-006 input1  input  DATA_W: window top-left sample.
- REQ-007 input2  input  DATA_W: window top-right sample.
- REQ-008 input3  input  DATA_W: window bottom-left sample.
- REQ-009 input4  input  DATA_W: window bottom-right sample.
- REQ-010 output1  output  DATA_W: registered maximum of the last accepted window.
- REQ-011 max_idx  output  2: registered index of the winning input (0 = input1 ... 3 = input4).
- REQ-012 done  output  1: registered result-valid strobe for output1/max_idx.

Function
- REQ-013 The block SHALL accept a window on every rising edge where rst=0 and enable=1, with no back-pressure and no idle cycles required between windows.
- REQ-014 Latency SHALL be exactly 1 cycle: a window sampled at edge N produces output1, max_idx and done=1 valid immediately after edge N.
- REQ-015 output1 SHALL equal max(input1, input2, input3, input4) under the comparison mode set by SIGNED_MODE.
- REQ-016 Compare structure: m01 = max(input1, input2); m23 = max(input3, input4); result = max(m01, m23); combinational, single stage.
- REQ-017 Ties SHALL resolve to the lowest index: a strict greater-than is required to displace an earlier operand; max_idx reports that index.
- REQ-018 When enable=1 on consecutive edges, done SHALL stay high continuously and output1 SHALL update every cycle (one result per window).
- REQ-019 At an edge with enable=0 (and rst=0), done SHALL go to 0 and output1/max_idx SHALL hold their previous values.
- REQ-020 Output width SHALL equal input width; no extension or saturation is permitted, since the result is always one of the inputs.
- REQ-021 No internal state other than the output registers is permitted; windows are independent.

Reset
- REQ-022 At an edge with rst=1: output1=0, max_idx=0, done=0, regardless of enable.
- REQ-023 rst SHALL take priority over enable; a window presented during the reset edge is discarded and produces no done pulse.
- REQ-024 First result after reset release: the first edge with rst=0 and enable=1; done=1 after that edge.

Verification
- REQ-025 Reset: rst=1 for 2 cycles with enable=1, inputs=4'hF -> output1=0, max_idx=0, done=0 throughout.
- REQ-026 Basic window (unsigned): enable=1 for one cycle, inputs 3,9,2,7 -> next cycle output1=9, max_idx=1, done=1; following cycle with enable=0 gives done=0 and output1 still 9.
- REQ-027 Streaming: 9 consecutive windows with maxima 5,8,15,1,0,12,7,3,10 -> done high 9 cycles, output1 sequence matches, 1-cycle lag, no gaps.
- REQ-028 Ties: inputs 6,6,6,6 -> output1=6, max_idx=0; inputs 2,4,4,1 -> output1=4, max_idx=1.
- REQ-029 Signed mode (SIGNED_MODE=1): inputs 4'b1111 (-1), 4'b0001 (1), 4'b1000 (-8), 4'b0000 -> output1=4'b0001, max_idx=1; with SIGNED_MODE=0, same inputs -> output1=4'b1111, max_idx=0.
- REQ-030 Reset mid-stream: rst=1 at an edge during continuous enable -> after that edge done=0 and output1=0; results resume 1 cycle after rst is deasserted.
